// File: rtl/mult_adder_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_adder_feeder_pkg                                                |
// | Shared tree geometry and collector state encodings for the feeder.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mult_adder_feeder_pkg;

  localparam int TAPS       = 64;
  localparam int MULT_WIDTH = 9;
  localparam int ADD_WIDTH  = 24;
  localparam int TREE_LAT   = 7;

  localparam int IDX_W = $clog2(TAPS);
  localparam int CNT_W = IDX_W + 1;
  localparam int LAT_W = $clog2(TREE_LAT + 1);
  localparam int VEC_W = TAPS * MULT_WIDTH;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mult_adder_feeder_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_adder_feeder_pack                                               |
// | Slot-indexed packing of pixel/weight pairs plus the window count.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mult_adder_feeder_pack
  import mult_adder_feeder_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_i,
  input  logic                  clr_i,
  input  logic [MULT_WIDTH-1:0] pixel_i,
  input  logic [MULT_WIDTH-1:0] weight_i,
  output logic [CNT_W-1:0]      count_o,
  output logic [VEC_W-1:0]      pixels_o,
  output logic [VEC_W-1:0]      weights_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             w_room;

  // count parks at TAPS while an oversized window drains; writes stop there
  assign w_room  = (count_q < CNT_W'(TAPS));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (wr_i && w_room) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  generate
    for (genvar i = 0; i < TAPS; i++) begin : g_slot
      logic [MULT_WIDTH-1:0] pix_q;
      logic [MULT_WIDTH-1:0] wgt_q;
      logic                  w_sel;

      assign w_sel = wr_i && w_room && (count_q[IDX_W-1:0] == IDX_W'(i));

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          pix_q <= '0;
          wgt_q <= '0;
        end else if (clr_i) begin
          pix_q <= '0;
          wgt_q <= '0;
        end else if (w_sel) begin
          pix_q <= pixel_i;
          wgt_q <= weight_i;
        end
      end

      assign pixels_o[MULT_WIDTH*i +: MULT_WIDTH]  = pix_q;
      assign weights_o[MULT_WIDTH*i +: MULT_WIDTH] = wgt_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mult_adder_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_adder_feeder                                                    |
// | Streams (pixel, weight) pairs into one tree window, launches it and  |
// | returns the biased sum. MULT_ADDER_FEEDER_RELU_EN clamps negatives.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mult_adder_feeder
  import mult_adder_feeder_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [MULT_WIDTH-1:0] s_pixel_i,
  input  logic [MULT_WIDTH-1:0] s_weight_i,
  input  logic [ADD_WIDTH-1:0]  s_bias_i,
  input  logic                  s_last_i,
  output logic [VEC_W-1:0]      ma_in_o,
  output logic [VEC_W-1:0]      ma_kernal_o,
  output logic [ADD_WIDTH-1:0]  ma_bias_o,
  input  logic [ADD_WIDTH-1:0]  ma_out_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [ADD_WIDTH-1:0]  m_data_o,
  output logic                  overrun_o
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     w_count;
  logic [VEC_W-1:0]     w_pixels, w_weights;
  logic                 w_xfer, w_launch, w_capture, w_last_slot;
  logic                 overrun_q, overrun_d;
  logic                 m_valid_q, m_valid_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [ADD_WIDTH-1:0] bias_q, ma_bias_q, m_data_q, w_result;

  assign s_ready_o   = (state_q == FILL);
  assign w_xfer      = s_valid_i && s_ready_o;
  assign w_last_slot = (w_count == CNT_W'(TAPS - 1));
  // a waiting window may launch on the very edge the old result is taken
  assign w_launch    = (state_q == FULL) && (lat_q == '0) && (!m_valid_q || m_ready_i);
  assign w_capture   = (lat_q == LAT_W'(1));

  mult_adder_feeder_pack u_pack (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_i      (w_xfer),
    .clr_i     (w_launch),
    .pixel_i   (s_pixel_i),
    .weight_i  (s_weight_i),
    .count_o   (w_count),
    .pixels_o  (w_pixels),
    .weights_o (w_weights)
  );

  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    case (state_q)
      FILL: begin
        if (w_xfer) begin
          if (s_last_i) begin
            state_d = FULL;
          end else if (w_last_slot) begin
            overrun_d = 1'b1;
          end
        end
      end
      FULL: begin
        if (w_launch) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    lat_d     = lat_q;
    m_valid_d = m_valid_q;
    if (w_launch) begin
      lat_d = LAT_W'(TREE_LAT);
    end else if (lat_q != '0) begin
      lat_d = lat_q - 1'b1;
    end
    if (w_capture) begin
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

`ifdef MULT_ADDER_FEEDER_RELU_EN
  assign w_result = ma_out_i[ADD_WIDTH-1] ? '0 : ma_out_i;
`else
  assign w_result = ma_out_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FILL;
      overrun_q <= 1'b0;
      lat_q     <= '0;
      m_valid_q <= 1'b0;
      bias_q    <= '0;
      ma_bias_q <= '0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
      lat_q     <= lat_d;
      m_valid_q <= m_valid_d;
      if (w_xfer && (w_count == '0)) begin
        bias_q <= s_bias_i;
      end
      // the tree adds the bias at its output, so hold it for the whole flight
      if (w_launch) begin
        ma_bias_q <= bias_q;
      end
      if (w_capture) begin
        m_data_q <= w_result;
      end
    end
  end

  assign ma_in_o     = w_launch ? w_pixels  : '0;
  assign ma_kernal_o = w_launch ? w_weights : '0;
  assign ma_bias_o   = ma_bias_q;
  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_adder_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mult_adder_feeder                                                 |
// | Directed bench with a behavioural 7-stage tree attached.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mult_adder_feeder;
  import mult_adder_feeder_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [MULT_WIDTH-1:0] s_pixel = '0;
  logic [MULT_WIDTH-1:0] s_weight = '0;
  logic [ADD_WIDTH-1:0]  s_bias = '0;
  logic                  s_last = 1'b0;
  logic [VEC_W-1:0]      ma_in, ma_kernal;
  logic [ADD_WIDTH-1:0]  ma_bias, ma_out, m_data;
  logic                  m_valid;
  logic                  m_ready = 1'b0;
  logic                  overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int launches = 0;
  int launch_edge = 0;
  logic [VEC_W-1:0] last_in = '0;
  logic [VEC_W-1:0] last_kern = '0;
  logic [ADD_WIDTH-1:0] pipe [TREE_LAT];

  always #5 clk = ~clk;

  mult_adder_feeder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_pixel_i   (s_pixel),
    .s_weight_i  (s_weight),
    .s_bias_i    (s_bias),
    .s_last_i    (s_last),
    .ma_in_o     (ma_in),
    .ma_kernal_o (ma_kernal),
    .ma_bias_o   (ma_bias),
    .ma_out_i    (ma_out),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .overrun_o   (overrun)
  );

  function automatic logic [ADD_WIDTH-1:0] tree_sum(input logic [VEC_W-1:0] a,
                                                    input logic [VEC_W-1:0] b);
    logic signed [ADD_WIDTH-1:0]  acc;
    logic signed [MULT_WIDTH-1:0] pa, pb;
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      pa  = a[k*MULT_WIDTH +: MULT_WIDTH];
      pb  = b[k*MULT_WIDTH +: MULT_WIDTH];
      acc = acc + ADD_WIDTH'(pa) * ADD_WIDTH'(pb);
    end
    return acc;
  endfunction

  // Tree stand-in: one multiply stage plus six adder stages, bias added at the output
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TREE_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= tree_sum(ma_in, ma_kernal);
      for (int k = 1; k < TREE_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign ma_out = pipe[TREE_LAT-1] + ma_bias;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ma_in != '0 || ma_kernal != '0) begin
      launches    = launches + 1;
      launch_edge = cyc;
      last_in     = ma_in;
      last_kern   = ma_kernal;
    end
  end

  task automatic send_pair(input logic [MULT_WIDTH-1:0] p, input logic [MULT_WIDTH-1:0] w,
                           input logic [ADD_WIDTH-1:0] b, input logic l);
    int guard;
    s_valid = 1'b1; s_pixel = p; s_weight = w; s_bias = b; s_last = l;
    guard = 0;
    while (!s_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!s_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int guard;
    guard = 0;
    while (!m_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++;
    if (m_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_timeout: m_valid=%0b required 1", name, m_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    n_cmp++; if (m_data !== 24'd0) begin n_bad++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    n_cmp++; if (ma_bias !== 24'd0) begin n_bad++; $display("FAIL reset_ma_bias: got %h want 0", ma_bias); end
    n_cmp++; if (ma_in !== '0 || ma_kernal !== '0) begin n_bad++; $display("FAIL reset_vectors: nonzero, want 0"); end
  endtask

  task automatic test_basic();
    int l0;
    logic [MULT_WIDTH-1:0] s8, s9;
    m_ready = 1'b1;
    l0 = launches;
    for (int i = 0; i < 9; i++) send_pair(9'sd2, 9'sd3, 24'd5, (i == 8));
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL basic_full_ready: got %0b want 0", s_ready); end
    @(posedge clk); #1;
    n_cmp++; if (launches - l0 !== 1) begin n_bad++; $display("FAIL basic_launch: got %0d want 1", launches - l0); end
    n_cmp++; if (ma_bias !== 24'd5) begin n_bad++; $display("FAIL basic_ma_bias: got %0d want 5", ma_bias); end
    n_cmp++; if (ma_in !== '0) begin n_bad++; $display("FAIL basic_cleared: ma_in nonzero after launch, want 0"); end
    s8 = last_in[8*MULT_WIDTH +: MULT_WIDTH];
    s9 = last_in[9*MULT_WIDTH +: MULT_WIDTH];
    n_cmp++; if (s8 !== 9'd2 || s9 !== 9'd0) begin n_bad++; $display("FAIL basic_slots: slot8=%0d slot9=%0d want 2 0", s8, s9); end
    wait_result("basic");
    n_cmp++; if (cyc - launch_edge !== TREE_LAT) begin n_bad++; $display("FAIL basic_latency: got %0d want 7", cyc - launch_edge); end
    n_cmp++; if (m_data !== 24'd59) begin n_bad++; $display("FAIL basic_data: got %0d want 59", m_data); end
    @(posedge clk); #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_clear: got %0b want 0", m_valid); end
  endtask

  task automatic test_full_window();
    logic [ADD_WIDTH-1:0] exp;
`ifdef MULT_ADDER_FEEDER_RELU_EN
    exp = 24'd0;
`else
    exp = 24'hFFFFC0;
`endif
    m_ready = 1'b1;
    for (int i = 0; i < TAPS; i++) send_pair(9'h1FF, 9'sd1, 24'd0, (i == TAPS - 1));
    wait_result("full");
    n_cmp++; if (m_data !== exp) begin n_bad++; $display("FAIL full_data: got %h want %h", m_data, exp); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL full_overrun: got %0b want 0", overrun); end
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    m_ready = 1'b1;
    for (int i = 0; i < TAPS; i++) send_pair(9'sd1, 9'sd2, 24'd0, 1'b0);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %0b want 1", overrun); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL ovr_drain_ready: got %0b want 1", s_ready); end
    send_pair(9'sd100, 9'sd100, 24'd0, 1'b0);
    send_pair(9'sd100, 9'sd100, 24'd0, 1'b1);
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL ovr_full_ready: got %0b want 0", s_ready); end
    wait_result("ovr");
    n_cmp++; if (m_data !== 24'd128) begin n_bad++; $display("FAIL ovr_data: got %0d want 128", m_data); end
    @(posedge clk); #1;
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
  endtask

  task automatic test_back_to_back();
    int l0;
    int bad_hold;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(9'sd1, 9'sd1, 24'd10, (i == 3));
    for (int i = 0; i < 4; i++) send_pair(9'sd2, 9'sd2, 24'd20, (i == 3));
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_ready: got %0b want 0", s_ready); end
    wait_result("b2b_first");
    n_cmp++; if (m_data !== 24'd14) begin n_bad++; $display("FAIL b2b_first_data: got %0d want 14", m_data); end
    l0 = launches;
    bad_hold = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b1 || m_data !== 24'd14 || s_ready !== 1'b0) bad_hold++;
    end
    n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL b2b_hold: %0d unstable cycles want 0", bad_hold); end
    n_cmp++; if (launches !== l0) begin n_bad++; $display("FAIL b2b_early_launch: got %0d launches want 0", launches - l0); end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    n_cmp++; if (launches - l0 !== 1 || launch_edge !== cyc) begin
      n_bad++; $display("FAIL b2b_launch_at_accept: launches=%0d edge=%0d want 1 at %0d", launches - l0, launch_edge, cyc);
    end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_accept_clear: got %0b want 0", m_valid); end
    wait_result("b2b_second");
    n_cmp++; if (m_data !== 24'd36) begin n_bad++; $display("FAIL b2b_second_data: got %0d want 36", m_data); end
    n_cmp++; if (cyc - launch_edge !== TREE_LAT) begin n_bad++; $display("FAIL b2b_latency: got %0d want 7", cyc - launch_edge); end
    m_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_inflight();
    int l0;
    int seen;
    logic [MULT_WIDTH-1:0] p0, w0;
    m_ready = 1'b1;
    l0 = launches;
    for (int i = 0; i < 4; i++) send_pair(9'sd3, 9'sd3, 24'd0, (i == 3));
    @(posedge clk); #1;
    n_cmp++; if (launches - l0 !== 1) begin n_bad++; $display("FAIL rst_launch: got %0d want 1", launches - l0); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_no_result: m_valid high %0d cycles want 0", seen); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %0b want 0", overrun); end
    send_pair(9'sd5, 9'sd7, 24'd0, 1'b1);
    @(posedge clk); #1;
    p0 = last_in[0 +: MULT_WIDTH];
    w0 = last_kern[0 +: MULT_WIDTH];
    n_cmp++; if (p0 !== 9'd5 || w0 !== 9'd7) begin n_bad++; $display("FAIL rst_slot0: got %0d,%0d want 5,7", p0, w0); end
    wait_result("rst_next");
    n_cmp++; if (m_data !== 24'd35) begin n_bad++; $display("FAIL rst_next_data: got %0d want 35", m_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    send_pair(9'h100, 9'h100, 24'hFFFFFF, 1'b1);
    wait_result("single");
    n_cmp++; if (m_data !== 24'd65535) begin n_bad++; $display("FAIL single_data: got %0d want 65535", m_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_full_window();
    test_overrun();
    test_back_to_back();
    test_reset_inflight();
    test_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
